// File: rtl/lut_mult_seq_ctrl_2b.sv
// lut_mult_seq_ctrl_2b: drives a registered 4x2 LUT multiplier one 2-bit digit of B at a time
//   and shift-accumulates the partial products into a 4 x (2*DIGITS)-bit unsigned product.
// Latency: start sampled at edge k -> done_2b high in cycle k+1+2*DIGITS. With
//   LUT_MULT_SEQ_ZERO_SKIP_EN defined, the run stops after the highest nonzero digit
//   (B = 0 finishes in cycle k+1).
// Backpressure: none; start_2b is sampled only in IDLE and ignored while busy_2b is high.
module lut_mult_seq_ctrl_2b #(
  parameter int DIGITS = 2
) (
  input  logic                    clk_2b,
  input  logic                    resetn_2b,
  input  logic                    start_2b,
  input  logic [3:0]              operand_a_2b,
  input  logic [2*DIGITS-1:0]     operand_b_2b,
  input  logic [7:0]              pp_result_2b,
  output logic [3:0]              mult_a_2b,
  output logic [1:0]              mult_b_2b,
  output logic                    busy_2b,
  output logic                    done_2b,
  output logic [4+2*DIGITS-1:0]   product_2b
);

  localparam int BW   = 2 * DIGITS;
  localparam int P    = 4 + BW;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          state;
  logic [3:0]      a_reg;
  logic [BW-1:0]   b_shift;
  logic [IDXW-1:0] idx;
  logic [P-1:0]    acc;

  // Datapath next-values used in CAPTURE
  logic [IDXW:0]   shamt;
  logic [P-1:0]    pp_ext;
  logic [P-1:0]    acc_nxt;
  logic [BW-1:0]   b_shift_nxt;
  logic            last_digit;

  // Early-termination decisions
  logic            capture_to_done;
  logic            start_to_done;

  // The multiplier sees the latched operand and the current low digit straight from registers
  assign mult_a_2b = a_reg;
  assign mult_b_2b = b_shift[1:0];

  // Align the captured partial product to its digit position and form the next accumulator value
  always_comb begin
    shamt       = {idx, 1'b0};
    pp_ext      = P'(pp_result_2b);
    acc_nxt     = acc + (pp_ext << shamt);
    b_shift_nxt = b_shift >> 2;
    last_digit  = (idx == LAST_IDX);
  end

`ifdef LUT_MULT_SEQ_ZERO_SKIP_EN
  // Stop as soon as no nonzero digits remain; a zero B never needs the multiplier at all
  assign capture_to_done = last_digit || (b_shift_nxt == '0);
  assign start_to_done   = (operand_b_2b == '0);
`else
  // Always walk every digit so latency is fixed
  assign capture_to_done = last_digit;
  assign start_to_done   = 1'b0;
`endif

  // Sequencing FSM; status outputs and product are registered alongside the state
  always_ff @(posedge clk_2b or negedge resetn_2b) begin
    if (!resetn_2b) begin
      state      <= S_IDLE;
      a_reg      <= '0;
      b_shift    <= '0;
      idx        <= '0;
      acc        <= '0;
      product_2b <= '0;
      busy_2b    <= 1'b0;
      done_2b    <= 1'b0;
    end else begin
      done_2b <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_2b) begin
            a_reg   <= operand_a_2b;
            b_shift <= operand_b_2b;
            idx     <= '0;
            acc     <= '0;
            busy_2b <= 1'b1;
            if (start_to_done) begin
              // Zero multiplier: result is known without issuing anything
              state      <= S_DONE;
              done_2b    <= 1'b1;
              product_2b <= '0;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // Multiplier registers mult_a_2b x mult_b_2b at the end of this cycle
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          acc     <= acc_nxt;
          b_shift <= b_shift_nxt;
          idx     <= idx + 1'b1;
          if (capture_to_done) begin
            // Publish the final sum together with the done pulse
            state      <= S_DONE;
            done_2b    <= 1'b1;
            product_2b <= acc_nxt;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_DONE: begin
          // start_2b is deliberately not looked at here; first IDLE cycle may accept it
          state   <= S_IDLE;
          busy_2b <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          busy_2b <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_mult_seq_ctrl_2b.sv
// tb_lut_mult_seq_ctrl_2b: directed checks of the digit sequencer wrapped around a registered 4x2 multiplier.
// Latency: expectations assume done in cycle k+5 for DIGITS=2 (shorter with LUT_MULT_SEQ_ZERO_SKIP_EN).
// Backpressure: none; inputs driven on falling edges, outputs sampled on falling edges.
module tb_lut_mult_seq_ctrl_2b;

  logic       clk_2b;
  logic       resetn_2b;
  logic       start_2b;
  logic [3:0] operand_a_2b;
  logic [3:0] operand_b_2b;
  logic [7:0] pp_result_2b;
  logic [3:0] mult_a_2b;
  logic [1:0] mult_b_2b;
  logic       busy_2b;
  logic       done_2b;
  logic [7:0] product_2b;

  int n_checks;
  int n_errors;
  int last_prod;
  int mb_at1;
  int mb_at3;

  lut_mult_seq_ctrl_2b #(.DIGITS(2)) dut (
    .clk_2b       (clk_2b),
    .resetn_2b    (resetn_2b),
    .start_2b     (start_2b),
    .operand_a_2b (operand_a_2b),
    .operand_b_2b (operand_b_2b),
    .pp_result_2b (pp_result_2b),
    .mult_a_2b    (mult_a_2b),
    .mult_b_2b    (mult_b_2b),
    .busy_2b      (busy_2b),
    .done_2b      (done_2b),
    .product_2b   (product_2b)
  );

  // Registered 4x2 partial-product multiplier: result valid one cycle after issue
  always_ff @(posedge clk_2b or negedge resetn_2b) begin
    if (!resetn_2b) pp_result_2b <= '0;
    else            pp_result_2b <= {4'b0, mult_a_2b} * {6'b0, mult_b_2b};
  end

  initial clk_2b = 1'b0;
  always #5 clk_2b = ~clk_2b;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one operation from an IDLE cycle; returns at the falling edge of the done cycle.
  // n counts cycles after the accepting edge, so done in cycle k+5 means n == 5.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input int lat, input int prod);
    int  n;
    bit  seen;
    @(negedge clk_2b);
    start_2b     = 1'b1;
    operand_a_2b = a;
    operand_b_2b = b;
    @(negedge clk_2b);
    start_2b     = 1'b0;
    n    = 1;
    seen = 1'b0;
    mb_at1 = -1;
    mb_at3 = -1;
    check({tag, "_busy"}, busy_2b, 1);
    while (!seen && n <= 20) begin
      if (n == 1) mb_at1 = mult_b_2b;
      if (n == 3) mb_at3 = mult_b_2b;
      if (done_2b) begin
        seen = 1'b1;
      end else begin
        check({tag, "_hold"}, product_2b, last_prod);
        @(negedge clk_2b);
        n++;
      end
    end
    check({tag, "_seen"}, seen, 1);
    check({tag, "_lat"}, n, lat);
    check({tag, "_prod"}, product_2b, prod);
    last_prod = prod;
  endtask

  initial begin
    int lat_b1;
    int lat_b0;
    int n_done;
    n_checks     = 0;
    n_errors     = 0;
    last_prod    = 0;
    resetn_2b    = 1'b0;
    start_2b     = 1'b0;
    operand_a_2b = '0;
    operand_b_2b = '0;
`ifdef LUT_MULT_SEQ_ZERO_SKIP_EN
    lat_b1 = 3;
    lat_b0 = 1;
`else
    lat_b1 = 5;
    lat_b0 = 5;
`endif

    // Reset state
    repeat (3) @(negedge clk_2b);
    check("rst_busy", busy_2b, 0);
    check("rst_done", done_2b, 0);
    check("rst_prod", product_2b, 0);
    check("rst_mb", mult_b_2b, 0);
    resetn_2b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_2b);
      check("idle_busy", busy_2b, 0);
      check("idle_done", done_2b, 0);
      check("idle_prod", product_2b, 0);
    end

    // 9 x 6: digits 2 then 1
    run_op("m9x6", 4'd9, 4'd6, 5, 54);
    check("m9x6_mb0", mb_at1, 2);
    check("m9x6_mb1", mb_at3, 1);
    check("m9x6_ma", mult_a_2b, 9);
    @(negedge clk_2b);
    check("m9x6_post_done", done_2b, 0);
    check("m9x6_post_busy", busy_2b, 0);

    // Maximum product, then back-to-back restart in the first IDLE cycle
    run_op("m15x15", 4'd15, 4'd15, 5, 225);
    run_op("m3x5", 4'd3, 4'd5, 5, 15);

    // start held high for 12 edges: two operations, each with one done pulse
    @(negedge clk_2b);
    @(negedge clk_2b);
    start_2b     = 1'b1;
    operand_a_2b = 4'd7;
    operand_b_2b = 4'd10;
    n_done = 0;
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk_2b);
      if (j == 12) start_2b = 1'b0;
      if (done_2b) begin
        n_done++;
        check("hold_prod", product_2b, 70);
        check("hold_done_cycle", j, (n_done == 1) ? 5 : 11);
      end
    end
    check("hold_ndone", n_done, 2);
    check("hold_busy_end", busy_2b, 0);
    last_prod = 70;

    // Asynchronous reset during CAPTURE of digit 0
    @(negedge clk_2b);
    start_2b     = 1'b1;
    operand_a_2b = 4'd5;
    operand_b_2b = 4'd9;
    @(negedge clk_2b);
    start_2b = 1'b0;
    @(negedge clk_2b);
    check("arst_pre_busy", busy_2b, 1);
    resetn_2b = 1'b0;
    #1;
    check("arst_busy", busy_2b, 0);
    check("arst_done", done_2b, 0);
    check("arst_prod", product_2b, 0);
    check("arst_ma", mult_a_2b, 0);
    check("arst_mb", mult_b_2b, 0);
    n_done = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk_2b);
      if (done_2b) n_done++;
    end
    resetn_2b = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk_2b);
      if (done_2b) n_done++;
    end
    check("arst_no_done", n_done, 0);
    last_prod = 0;
    run_op("m5x9", 4'd5, 4'd9, 5, 45);

    // Single low digit and zero multiplier
    run_op("m12x1", 4'd12, 4'd1, lat_b1, 12);
    run_op("m12x0", 4'd12, 4'd0, lat_b0, 0);
    @(negedge clk_2b);
    check("end_busy", busy_2b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
